ldmac_key_schedule: RTL
=======================

# ldmac_key_schedule

Sequential round-key generator for the LDMAC datapath. It generalises the fixed one-shot key update into a parametrised engine with word width, word count, half-word rotation amounts and round count as parameters. It keeps the master key, steps forward or backward through the schedule, and seeks to an arbitrary round. Round keys go to the MAC core over a valid/ready handshake, one per command.

## Interface
- `WORD_W`, 32: word width in bits; must be even.
- `NUM_WORDS`, 4: words per key; key width `KEY_W = WORD_W*NUM_WORDS`.
- `ROT_LO`, 4: left-rotate amount applied to the low half of word 0.
- `ROT_HI`, 2: right-rotate amount applied to the high half of word 0.
- `ROUNDS`, 48: number of round keys, indices 0..ROUNDS-1; `ROUND_W = $clog2(ROUNDS)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  0 LOAD, 1 FWD, 2 REV, 3 SEEK.
- `cmd_key`  in  KEY_W  master key; used by LOAD only.
- `cmd_round`  in  ROUND_W  target round; used by SEEK only.
- `rk_valid`  out  1  round key available.
- `rk_ready`  in  1  consumer accepts the round key.
- `rk_data`  out  KEY_W  current round key.
- `rk_round`  out  ROUND_W  index of `rk_data`.
- `err`  out  1  one-cycle pulse when a command is rejected.

## Operation
- Word i is `key[WORD_W*i +: WORD_W]`.
- P(w), forward permutation of one word:
  - low half is rotated left by ROT_LO;
  - high half is rotated right by ROT_HI.
- Forward step:
  - new word NUM_WORDS-1 = P(old word 0);
  - new word i = old word i+1, for i < NUM_WORDS-1.
- Reverse step:
  - new word 0 = P⁻¹(old word NUM_WORDS-1);
  - new word i = old word i-1, for i > 0.
- FSM states:
  - IDLE: `cmd_ready = !rk_valid`.
  - SEEK: one forward step per cycle.
  - RELOAD: state := master, round := 0.
- LOAD: master := state := `cmd_key`; round := 0; `rk_valid` set.
- FWD: one forward step, round+1, `rk_valid` set.
  - At round ROUNDS-1 the command is rejected: `err` pulses, state and round are unchanged, `rk_valid` stays 0.
- REV: one reverse step, round-1, `rk_valid` set.
  - At round 0 the command is rejected with `err`.
- SEEK, with target t:
  - t ≥ ROUNDS: rejected with `err`.
  - t == round: no step; `rk_valid` set the next cycle.
  - t > round: go to SEEK and step until round == t, then IDLE with `rk_valid`.
  - t < round: go to RELOAD for one cycle, then SEEK from round 0.
- `rk_valid` clears on `rk_valid && rk_ready`. `rk_data`/`rk_round` are stable while `rk_valid` is high.
- While `rk_valid` is high, `cmd_ready` is 0, so no new command is accepted in the same cycle as the handshake.
- Reset values: state 0, master 0, round 0, FSM IDLE, `rk_valid` 0, `err` 0, `cmd_ready` 1 (after reset release).
- Reset asserted mid-SEEK aborts immediately to the reset values. The master key is lost.

## Timing
- Command accepted at edge T:
  - LOAD/FWD/REV: `rk_valid` is high from T+1.
  - SEEK forward by k: `rk_valid` from T+k.
  - SEEK to the current round: `rk_valid` from T+1.
  - SEEK backward to t: `rk_valid` from T+1+t; t=0 gives T+1.
- `err` is high for exactly the cycle after the rejecting edge.
- No combinational path from `cmd_*` to `rk_*`. `cmd_ready` depends only on registers.

## Structure
- `ldmac_pkg` holds:
  - the `cmd_op` enum (OP_LOAD, OP_FWD, OP_REV, OP_SEEK);
  - the FSM state enum.
- Sub-module `ldmac_key_perm`: combinational, parametrised by WORD_W/NUM_WORDS/ROT_LO/ROT_HI. It produces both the forward-step and reverse-step next key from the current key, and is used by the top FSM.
- The FSM, round counter, master register and handshake logic sit in the top module.

## Test plan
- Default parameters, LOAD with key 0x00000000_00000000_00000000_12345678, then FWD → `rk_data` = 0x048D6785_00000000_00000000_00000000, `rk_round` = 1.
- From that state, REV → `rk_data` = 0x…12345678 again, `rk_round` = 0. A second REV → `err` pulse, no `rk_valid`, state unchanged.
- LOAD random key, SEEK 47 → `rk_valid` exactly 47 cycles after acceptance, `rk_data` equal to 47 chained forward steps. Then FWD → `err`.
- At round 20, SEEK 5 → `rk_valid` 6 cycles after acceptance, `rk_round` = 5, data matching the model. SEEK 5 again → `rk_valid` the next cycle.
- Hold `rk_ready`=0 for 10 cycles → `rk_valid`/`rk_data` stable and `cmd_ready`=0 throughout. Releasing `rk_ready` → `cmd_ready`=1 the cycle after.
- Assert `rst` mid-SEEK (cycle 3 of 30) → all outputs at reset values asynchronously. After release, FWD gives P applied to the zero key, i.e. all zeros, round 1.

Source files
------------

// File: rtl/ldmac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ldmac_pkg
// Brief    : Shared command and FSM encodings for the LDMAC key schedule.
// Revision : 1.0 - initial release
// ============================================================================
package ldmac_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_FWD  = 2'd1,
        OP_REV  = 2'd2,
        OP_SEEK = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEEK   = 2'd1,
        ST_RELOAD = 2'd2
    } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/ldmac_key_perm.sv
`default_nettype none
// ============================================================================
// Module   : ldmac_key_perm
// Brief    : Combinational forward and reverse single-step key permutation.
// Revision : 1.0 - initial release
// ============================================================================
module ldmac_key_perm
    import ldmac_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int ROT_LO    = 4,
    parameter int ROT_HI    = 2
) (
    input  logic [WORD_W*NUM_WORDS-1:0] i_key,
    output logic [WORD_W*NUM_WORDS-1:0] o_fwd_key,
    output logic [WORD_W*NUM_WORDS-1:0] o_rev_key
);

    localparam int c_half  = WORD_W / 2;
    localparam int c_key_w = WORD_W * NUM_WORDS;
    localparam int c_rl    = ROT_LO % c_half;
    localparam int c_rh    = ROT_HI % c_half;

    // Rotations are taken as part-selects of each half concatenated with itself.
    logic [2*c_half-1:0] w_f_lo2;
    logic [2*c_half-1:0] w_f_hi2;
    logic [2*c_half-1:0] w_r_lo2;
    logic [2*c_half-1:0] w_r_hi2;

    assign w_f_lo2 = {2{i_key[c_half-1:0]}};
    assign w_f_hi2 = {2{i_key[WORD_W-1:c_half]}};
    assign w_r_lo2 = {2{i_key[c_key_w-WORD_W +: c_half]}};
    assign w_r_hi2 = {2{i_key[c_key_w-c_half +: c_half]}};

    assign o_fwd_key[c_key_w-WORD_W +: WORD_W] = {w_f_hi2[c_rh +: c_half],
                                                  w_f_lo2[2*c_half-1-c_rl -: c_half]};
    assign o_rev_key[WORD_W-1:0]               = {w_r_hi2[2*c_half-1-c_rh -: c_half],
                                                  w_r_lo2[c_rl +: c_half]};

    for (genvar i = 0; i < NUM_WORDS - 1; i++) begin : g_shift
        assign o_fwd_key[WORD_W*i +: WORD_W]     = i_key[WORD_W*(i+1) +: WORD_W];
        assign o_rev_key[WORD_W*(i+1) +: WORD_W] = i_key[WORD_W*i +: WORD_W];
    end

endmodule
`default_nettype wire

// File: rtl/ldmac_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : ldmac_key_schedule
// Brief    : Sequential round-key generator with step, reverse and seek.
// Revision : 1.0 - initial release
// ============================================================================
module ldmac_key_schedule
    import ldmac_pkg::*;
#(
    parameter  int WORD_W    = 32,
    parameter  int NUM_WORDS = 4,
    parameter  int ROT_LO    = 4,
    parameter  int ROT_HI    = 2,
    parameter  int ROUNDS    = 48,
    localparam int KEY_W     = WORD_W * NUM_WORDS,
    localparam int ROUND_W   = $clog2(ROUNDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [KEY_W-1:0]   cmd_key,
    input  logic [ROUND_W-1:0] cmd_round,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [KEY_W-1:0]   rk_data,
    output logic [ROUND_W-1:0] rk_round,
    output logic               err
);

    localparam logic [ROUND_W-1:0] c_last_round = ROUND_W'(ROUNDS - 1);
    localparam logic [ROUND_W-1:0] c_round_one  = ROUND_W'(1);

    fsm_state_e         r_fsm,      w_fsm_nxt;
    logic [KEY_W-1:0]   r_key,      w_key_nxt;
    logic [KEY_W-1:0]   r_master,   w_master_nxt;
    logic [ROUND_W-1:0] r_round,    w_round_nxt;
    logic [ROUND_W-1:0] r_target,   w_target_nxt;
    logic               r_rk_valid, w_rk_valid_nxt;
    logic               r_err,      w_err_nxt;
    logic [KEY_W-1:0]   w_perm_in;
    logic [KEY_W-1:0]   w_fwd_key;
    logic [KEY_W-1:0]   w_rev_key;
    logic [ROUND_W-1:0] w_round_inc;
    logic               w_cmd_fire;

    // RELOAD folds the restart from the master key into the first forward step.
    assign w_perm_in   = (r_fsm == ST_RELOAD) ? r_master : r_key;
    assign w_round_inc = r_round + 1'b1;
    assign cmd_ready   = (r_fsm == ST_IDLE) && !r_rk_valid;
    assign w_cmd_fire  = cmd_valid && cmd_ready;

    assign rk_valid = r_rk_valid;
    assign rk_data  = r_key;
    assign rk_round = r_round;
    assign err      = r_err;

    ldmac_key_perm #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .ROT_LO    (ROT_LO),
        .ROT_HI    (ROT_HI)
    ) u_perm (
        .i_key     (w_perm_in),
        .o_fwd_key (w_fwd_key),
        .o_rev_key (w_rev_key)
    );

    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_key_nxt      = r_key;
        w_master_nxt   = r_master;
        w_round_nxt    = r_round;
        w_target_nxt   = r_target;
        w_rk_valid_nxt = r_rk_valid && !rk_ready;
        w_err_nxt      = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    case (cmd_op_e'(cmd_op))
                        OP_LOAD: begin
                            w_master_nxt   = cmd_key;
                            w_key_nxt      = cmd_key;
                            w_round_nxt    = '0;
                            w_rk_valid_nxt = 1'b1;
                        end
                        OP_FWD: begin
                            if (r_round == c_last_round) begin
                                w_err_nxt = 1'b1;
                            end else begin
                                w_key_nxt      = w_fwd_key;
                                w_round_nxt    = w_round_inc;
                                w_rk_valid_nxt = 1'b1;
                            end
                        end
                        OP_REV: begin
                            if (r_round == '0) begin
                                w_err_nxt = 1'b1;
                            end else begin
                                w_key_nxt      = w_rev_key;
                                w_round_nxt    = r_round - 1'b1;
                                w_rk_valid_nxt = 1'b1;
                            end
                        end
                        OP_SEEK: begin
                            w_target_nxt = cmd_round;
                            if (cmd_round > c_last_round) begin
                                w_err_nxt = 1'b1;
                            end else if (cmd_round == r_round) begin
                                w_rk_valid_nxt = 1'b1;
                            end else if (cmd_round > r_round) begin
                                // The accepting edge already performs the first step.
                                w_key_nxt   = w_fwd_key;
                                w_round_nxt = w_round_inc;
                                if (cmd_round == w_round_inc) begin
                                    w_rk_valid_nxt = 1'b1;
                                end else begin
                                    w_fsm_nxt = ST_SEEK;
                                end
                            end else if (cmd_round == '0) begin
                                w_key_nxt      = r_master;
                                w_round_nxt    = '0;
                                w_rk_valid_nxt = 1'b1;
                            end else begin
                                w_fsm_nxt = ST_RELOAD;
                            end
                        end
                    endcase
                end
            end
            ST_SEEK: begin
                w_key_nxt   = w_fwd_key;
                w_round_nxt = w_round_inc;
                if (w_round_inc == r_target) begin
                    w_rk_valid_nxt = 1'b1;
                    w_fsm_nxt      = ST_IDLE;
                end
            end
            ST_RELOAD: begin
                w_key_nxt   = w_fwd_key;
                w_round_nxt = c_round_one;
                if (r_target == c_round_one) begin
                    w_rk_valid_nxt = 1'b1;
                    w_fsm_nxt      = ST_IDLE;
                end else begin
                    w_fsm_nxt = ST_SEEK;
                end
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm      <= ST_IDLE;
            r_key      <= '0;
            r_master   <= '0;
            r_round    <= '0;
            r_target   <= '0;
            r_rk_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_key      <= w_key_nxt;
            r_master   <= w_master_nxt;
            r_round    <= w_round_nxt;
            r_target   <= w_target_nxt;
            r_rk_valid <= w_rk_valid_nxt;
            r_err      <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire
